// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment driver: binary value converted by a double-dabble FSM (or
// sliced into hex nibbles), latched into a display register and scanned out digit by digit.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for load
// CONV   | one double-dabble iteration per clock
// DONE   | commit digits, blank mask and overflow to the display register
module seg7_scan_driver #(
    parameter int DATA_WIDTH     = 14,
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] number,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    // Add 3 to each nibble >= 5, then shift in the next binary bit; the top bit falls off.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic in_bit);
        logic [BCD_W-1:0] adj;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return {adj[BCD_W-2:0], in_bit};
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        case (d)
            4'h0: encode = 8'h3F;  4'h1: encode = 8'h06;
            4'h2: encode = 8'h5B;  4'h3: encode = 8'h4F;
            4'h4: encode = 8'h66;  4'h5: encode = 8'h6D;
            4'h6: encode = 8'h7D;  4'h7: encode = 8'h07;
            4'h8: encode = 8'h7F;  4'h9: encode = 8'h6F;
            4'hA: encode = 8'h77;  4'hB: encode = 8'h7C;
            4'hC: encode = 8'h39;  4'hD: encode = 8'h5E;
            4'hE: encode = 8'h79;  default: encode = 8'h71;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shf_q, shf_d;
    logic                    hex_q, hex_d;
    logic                    blz_q, blz_d;
    logic                    ovf_cap_q, ovf_cap_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BCD_W-1:0]        disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    overflow_q, overflow_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

    logic [63:0]             number_ext;
    logic [BCD_W-1:0]        hex_val;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_dig;

    assign number_ext = 64'(number);

    generate
        if (DATA_WIDTH >= BCD_W) begin : g_hex_trunc
            assign hex_val = shf_q[BCD_W-1:0];
        end else begin : g_hex_ext
            assign hex_val = {{(BCD_W-DATA_WIDTH){1'b0}}, shf_q};
        end
    endgenerate

    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
            lz_mask[i] = !seen;
        end
    end

    always_comb begin
        state_d    = state_q;
        shf_d      = shf_q;
        hex_d      = hex_q;
        blz_d      = blz_q;
        ovf_cap_d  = ovf_cap_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shf_d     = number;
                    hex_d     = hex_mode;
                    blz_d     = blank_lz;
                    ovf_cap_d = hex_mode ? ((number_ext >> BCD_W) != 64'd0)
                                         : (number_ext >= DEC_LIMIT);
                    bcd_d     = '0;
                    cnt_d     = CNT_W'(DATA_WIDTH - 1);
                    state_d   = hex_mode ? S_DONE : S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = dd_step(bcd_q, shf_q[DATA_WIDTH-1]);
                shf_d = shf_q << 1;
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                disp_d     = hex_q ? hex_val : bcd_q;
                blank_d    = (!hex_q && blz_q) ? lz_mask : '0;
                overflow_d = ovf_cap_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        cur_dig = disp_q[int'(idx_q)*4 +: 4];
        if (overflow_q)          seg_d = 8'h40;
        else if (blank_q[idx_q]) seg_d = 8'h00;
        else                     seg_d = encode(cur_dig);
        seg_d    = seg_d ^ SEG_OFF;
        dig_en_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shf_q      <= '0;
            hex_q      <= 1'b0;
            blz_q      <= 1'b0;
            ovf_cap_q  <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            blank_q    <= '0;
            overflow_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_OFF;
            dig_en_q   <= DIG_OFF;
        end else begin
            state_q    <= state_d;
            shf_q      <= shf_d;
            hex_q      <= hex_d;
            blz_q      <= blz_d;
            ovf_cap_q  <= ovf_cap_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;
    assign seg      = seg_q;
    assign dig_en   = dig_en_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multi-digit 7-segment display driver; the clocked successor of the combinational per-digit encoder.
- Accepts a binary value on a load strobe and converts it with an iterative double-dabble FSM (decimal) or direct nibble slicing (hex).
- Holds the result in a display register and time-multiplexes the digits with a prescaled scan counter.
- Sits between application logic and the board's segment and digit-enable pins.

Parameters:
- DATA_WIDTH, 14, width of the input value.
- NUM_DIGITS, 4, number of display digits (1..8).
- SCAN_DIV, 50000, clk cycles each digit stays lit (>=2).
- SEG_ACTIVE_LOW, 0, 1 inverts seg outputs.
- DIG_ACTIVE_LOW, 1, 1 inverts dig_en outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- number  in  DATA_WIDTH  value to display, sampled on load.
- load  in  1  single-cycle strobe; captures number and hex_mode.
- hex_mode  in  1  1 = hexadecimal digits, 0 = decimal.
- blank_lz  in  1  1 = blank leading zeros (decimal mode only).
- busy  out  1  conversion in progress; load is ignored while high.
- overflow  out  1  last loaded value does not fit in NUM_DIGITS.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}; dp always off.
- dig_en  out  NUM_DIGITS  one-hot digit enable; bit 0 = least significant digit.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; busy=0, overflow=0.
  - Display register = all digits 0; prescaler=0; scan index=0.
  - seg and dig_en = inactive level (all off, after polarity).
- FSM states:
  - IDLE: load=1 captures number, hex_mode and blank_lz into shadow registers, then goes to CONV if decimal or DONE if hex. busy=1 from the next edge.
  - CONV: one double-dabble iteration per clock (add 3 to every BCD nibble >=5, then shift left 1). Lasts exactly DATA_WIDTH cycles. BCD register is 4*NUM_DIGITS bits; the excess high-order bits are dropped.
  - DONE: one cycle. Writes digits, the blank mask and overflow to the display register, returns to IDLE and clears busy.
- Latency:
  - Decimal: the display register updates on edge DATA_WIDTH+1 after the load edge.
  - Hex: the display register updates on edge 1 after the load edge.
- Overflow:
  - Decimal: captured number >= 10^NUM_DIGITS.
  - Hex: any bit at or above 4*NUM_DIGITS is set.
  - When set, every digit shows dash (0x40). The flag holds until the next completed load.
- Blanking:
  - Applies in decimal mode with blank_lz=1.
  - Digits above the most significant nonzero digit show 0x00.
  - Digit 0 is never blanked, so value 0 shows "0".
- load while busy=1 is ignored entirely. The in-flight conversion completes with its original value.
- The display register changes only in DONE, so the scan never shows partial BCD.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; on wrap, the scan index advances 0..NUM_DIGITS-1 and wraps to 0.
  - Scanning runs continuously and independently of the FSM.
- Outputs:
  - seg and dig_en are registered and reflect the current index one cycle later.
  - dig_en is one-hot on the index (after polarity).
  - seg carries the encoded digit or blank (after polarity).
- Segment codes (active-high, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 dash:40 blank:00.
- rst during CONV aborts the conversion and returns every register to its reset value; no partial result is displayed.

Test Plan:
- SCAN_DIV=4, load 1234 decimal, blank_lz=0 -> busy high 15 cycles; seg over indices 0..3 = 66,4F,5B,06 (SEG_ACTIVE_LOW=0); dig_en (DIG_ACTIVE_LOW=1) = 1110,1101,1011,0111, each held 4 cycles.
- load 0x3A5F hex_mode=1 -> busy high 1 cycle; indices 0..3 show 71,6D,77,4F; overflow=0.
- load 12000 decimal -> overflow=1; all digits show 40. Then load 9999 -> overflow=0; all digits show 6F.
- blank_lz=1: load 7 -> seg 07,00,00,00. Load 0 -> 3F,00,00,00. Load 305 -> 6D,3F,4F,00.
- load 1234, then load 5678 three cycles later -> second load ignored; display 1234. A load after busy falls -> 5678 displayed.
- load 9999, assert rst 5 cycles into CONV -> busy=0, overflow=0, outputs inactive. After release, scan shows 3F on all digits; 9999 never appears.
